// File: rtl/diffeq_pkg.sv
// Shared constants for the differential-equation functional-unit core.
package diffeq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// Signed add/subtract with wrap-around result and signed-overflow flag. Purely combinational.
module adder_subtractor
    import diffeq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    input  logic                    mode,
    output logic signed [WIDTH-1:0] out,
    output logic                    ovf
);

    logic sign1;
    logic sign2_eff;
    logic sign_out;

    assign out       = (mode == MODE_SUB) ? (in1 - in2) : (in1 + in2);

    // Sign of -in2 taken at full precision, so -MIN counts as positive.
    assign sign1     = in1[WIDTH-1];
    assign sign2_eff = (mode == MODE_SUB) ? ~in2[WIDTH-1] : in2[WIDTH-1];
    assign sign_out  = out[WIDTH-1];
    assign ovf       = (sign1 == sign2_eff) && (sign_out != sign1);

endmodule

// File: rtl/multiplier.sv
// Signed multiplier: truncated product plus signed-overflow flag. Purely combinational.
module multiplier
    import diffeq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0] in1,
    input  logic signed [IN_WIDTH-1:0] in2,
    output logic signed [IN_WIDTH-1:0] out,
    output logic                       ovf
);

    localparam int unsigned PW = 2 * IN_WIDTH;

    logic signed [PW-1:0]     prod;
    logic        [IN_WIDTH:0] prod_top;

    assign prod     = $signed(PW'(in1)) * $signed(PW'(in2));
    assign out      = prod[IN_WIDTH-1:0];

    // Product fits in IN_WIDTH signed bits only if the top IN_WIDTH+1 bits agree.
    assign prod_top = prod[PW-1:IN_WIDTH-1];
    assign ovf      = !((&prod_top) || !(|prod_top));

endmodule

// File: rtl/diffeq_fu_core.sv
// Two multipliers and one add/sub with combinational results and an enabled output register bank.
module diffeq_fu_core
    import diffeq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] v1,
    input  logic signed [WIDTH-1:0] v2,
    input  logic signed [WIDTH-1:0] v3,
    input  logic signed [WIDTH-1:0] v4,
    input  logic signed [WIDTH-1:0] v5,
    input  logic signed [WIDTH-1:0] v6,
    input  logic                    mode,
    output logic signed [WIDTH-1:0] w1,
    output logic signed [WIDTH-1:0] w2,
    output logic signed [WIDTH-1:0] w3,
    output logic signed [WIDTH-1:0] r1,
    output logic signed [WIDTH-1:0] r2,
    output logic signed [WIDTH-1:0] r3,
    output logic                    ovf1,
    output logic                    ovf2,
    output logic                    ovf3,
    output logic                    valid
);

    logic m1_ovf, m2_ovf, a1_ovf;

    logic signed [WIDTH-1:0] r1_d, r1_q;
    logic signed [WIDTH-1:0] r2_d, r2_q;
    logic signed [WIDTH-1:0] r3_d, r3_q;
    logic                    ovf1_d, ovf1_q;
    logic                    ovf2_d, ovf2_q;
    logic                    ovf3_d, ovf3_q;
    logic                    valid_d, valid_q;

    multiplier #(.IN_WIDTH(WIDTH)) u_m1 (
        .in1 (v1),
        .in2 (v2),
        .out (w1),
        .ovf (m1_ovf)
    );

    multiplier #(.IN_WIDTH(WIDTH)) u_m2 (
        .in1 (v3),
        .in2 (v4),
        .out (w2),
        .ovf (m2_ovf)
    );

    adder_subtractor #(.WIDTH(WIDTH)) u_a1 (
        .in1  (v5),
        .in2  (v6),
        .mode (mode),
        .out  (w3),
        .ovf  (a1_ovf)
    );

    // Capture on en; otherwise hold results and drop valid.
    always_comb begin
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        ovf1_d  = ovf1_q;
        ovf2_d  = ovf2_q;
        ovf3_d  = ovf3_q;
        valid_d = 1'b0;
        if (en) begin
            r1_d    = w1;
            r2_d    = w2;
            r3_d    = w3;
            ovf1_d  = m1_ovf;
            ovf2_d  = m2_ovf;
            ovf3_d  = a1_ovf;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            ovf3_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
            ovf3_q  <= ovf3_d;
            valid_q <= valid_d;
        end
    end

    assign r1    = r1_q;
    assign r2    = r2_q;
    assign r3    = r3_q;
    assign ovf1  = ovf1_q;
    assign ovf2  = ovf2_q;
    assign ovf3  = ovf3_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_diffeq_fu_core.sv
// Self-checking bench for diffeq_fu_core: vector table, random vectors vs. a range-check model, reset/hold sequences.
module tb_diffeq_fu_core;
    import diffeq_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        int   v1, v2, v3, v4, v5, v6;
        logic mode;
        int   w1, w2, w3;
        logic o1, o2, o3;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset, en, mode;
    logic signed [W-1:0] v1, v2, v3, v4, v5, v6;
    logic signed [W-1:0] w1, w2, w3, r1, r2, r3;
    logic                ovf1, ovf2, ovf3, valid;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[8];
    vec_t mon_e;

    diffeq_fu_core #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .mode(mode),
        .w1(w1), .w2(w2), .w3(w3), .r1(r1), .r2(r2), .r3(r3),
        .ovf1(ovf1), .ovf2(ovf2), .ovf3(ovf3), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int e, input int f, input logic m,
                                input int e1, input int e2, input int e3,
                                input logic f1, input logic f2, input logic f3);
        vec_t v;
        v.v1 = a; v.v2 = b; v.v3 = c; v.v4 = d; v.v5 = e; v.v6 = f; v.mode = m;
        v.w1 = e1; v.w2 = e2; v.w3 = e3; v.o1 = f1; v.o2 = f2; v.o3 = f3;
        return v;
    endfunction

    function automatic int wrap16(input int x);
        logic signed [W-1:0] t;
        t = 16'(x);
        return t;
    endfunction

    function automatic logic out_of_range(input int x);
        return (x > 32767) || (x < -32768);
    endfunction

    // Reference: exact integer arithmetic, then wrap and range-check.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   p1, p2, s;
        r  = v;
        p1 = v.v1 * v.v2;
        p2 = v.v3 * v.v4;
        s  = v.mode ? (v.v5 - v.v6) : (v.v5 + v.v6);
        r.w1 = wrap16(p1); r.o1 = out_of_range(p1);
        r.w2 = wrap16(p2); r.o2 = out_of_range(p2);
        r.w3 = wrap16(s);  r.o3 = out_of_range(s);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        v1 = 16'(v.v1); v2 = 16'(v.v2); v3 = 16'(v.v3);
        v4 = 16'(v.v4); v5 = 16'(v.v5); v6 = 16'(v.v6);
        mode = v.mode;
    endtask

    // Drive at negedge, check combinational outputs, queue the registered expectation.
    task automatic apply_vec(input vec_t v);
        drive(v);
        en = 1'b1;
        #1;
        chk("w1", w1, v.w1);
        chk("w2", w2, v.w2);
        chk("w3", w3, v.w3);
        sb.push_back(v);
        @(negedge clk);
    endtask

    // Scoreboard: every valid pulse must match the oldest queued capture.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_unexpected: got valid=1 expected no capture (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("r1", r1, mon_e.w1);
                chk("r2", r2, mon_e.w2);
                chk("r3", r3, mon_e.w3);
                chk("ovf1", ovf1, mon_e.o1);
                chk("ovf2", ovf2, mon_e.o2);
                chk("ovf3", ovf3, mon_e.o3);
            end
        end
    end

    initial begin
        vec_t rv;
        vec_t hv;

        reset = 1'b1; en = 1'b0; mode = 1'b0;
        v1 = '0; v2 = '0; v3 = '0; v4 = '0; v5 = '0; v6 = '0;

        tbl[0] = mk(-2, 3, 4, 5, 5, 7, 1'b1,          -6, 20, -2,        1'b0, 1'b0, 1'b0);
        tbl[1] = mk(-2, 3, 4, 5, 5, 7, 1'b0,          -6, 20, 12,        1'b0, 1'b0, 1'b0);
        tbl[2] = mk(300, 300, 0, 0, 32767, 1, 1'b0,   24464, 0, -32768,  1'b1, 1'b0, 1'b1);
        tbl[3] = mk(-1, -32768, 0, 0, -32768, 1, 1'b1, -32768, 0, 32767, 1'b1, 1'b0, 1'b1);
        tbl[4] = mk(181, 181, -32768, 1, -1, -1, 1'b0, 32761, -32768, -2, 1'b0, 1'b0, 1'b0);
        tbl[5] = mk(182, 181, -256, 128, -32768, -1, 1'b0, -32594, -32768, 32767, 1'b1, 1'b0, 1'b1);
        tbl[6] = mk(-32768, -32768, 256, 128, 32767, -1, 1'b1, 0, -32768, -32768, 1'b1, 1'b1, 1'b1);
        tbl[7] = mk(0, 123, 7, -9, 100, 100, 1'b1,    0, -63, 0,         1'b0, 1'b0, 1'b0);

        #2;
        chk("reset_r1", r1, 0);
        chk("reset_r2", r2, 0);
        chk("reset_r3", r3, 0);
        chk("reset_ovf", {29'd0, ovf1, ovf2, ovf3}, 0);
        chk("reset_valid", valid, 0);

        @(negedge clk);
        reset = 1'b0;

        // mode flip must reach w3 without a clock edge
        drive(tbl[0]);
        #1;
        chk("w3_sub", w3, -2);
        mode = MODE_ADD;
        #1;
        chk("w3_add", w3, 12);
        @(negedge clk);

        for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rv.v1 = int'($urandom_range(65535)) - 32768;
            rv.v2 = (i % 2 == 0) ? int'($urandom_range(400)) - 200 : int'($urandom_range(65535)) - 32768;
            rv.v3 = int'($urandom_range(65535)) - 32768;
            rv.v4 = int'($urandom_range(16)) - 8;
            rv.v5 = int'($urandom_range(65535)) - 32768;
            rv.v6 = int'($urandom_range(65535)) - 32768;
            rv.mode = 1'($urandom_range(1));
            apply_vec(model(rv));
        end
        en = 1'b0;
        @(negedge clk);

        // hold: capture r1=20 with ovf3 set, then three idle clocks
        hv = model(mk(4, 5, 1, 1, 32767, 1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0));
        drive(hv);
        en = 1'b1;
        sb.push_back(hv);
        @(negedge clk);
        en = 1'b0;
        chk("capture_valid", valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("hold_r1", r1, 20);
            chk("hold_ovf3", ovf3, 1);
            chk("hold_valid", valid, 0);
        end

        // asynchronous reset between edges
        #1;
        reset = 1'b1;
        #1;
        chk("async_r1", r1, 0);
        chk("async_r3", r3, 0);
        chk("async_ovf3", ovf3, 0);
        chk("async_valid", valid, 0);
        chk("async_w1", w1, 20);
        @(negedge clk);
        reset = 1'b0;

        // reset covering a capture edge wins; capture lost
        drive(tbl[2]);
        en = 1'b1;
        #4;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("midcap_r1", r1, 0);
        chk("midcap_ovf1", ovf1, 0);
        chk("midcap_valid", valid, 0);
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(tbl[2]);
        @(negedge clk);
        en = 1'b0;
        chk("post_reset_r1", r1, 24464);
        chk("post_reset_valid", valid, 1);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
